regfile_dump_ctrl: RTL

- Run/scan sequencer placed between the processor and the register file.
- Enables the processor for a programmed number of clock cycles, then freezes it.
- Takes ownership of regfile read port A and streams all registers out, one at a time, over a valid/ready interface.
- Replaces bench-side rs1 hijacking with a synthesizable block usable on board (UART/LED dump).

---
 rtl/regfile_dump_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_dump_ctrl.sv
// Run/scan sequencer: enables the processor for a programmed number of cycles,
// then freezes it and streams every register out over a valid/ready interface.
module regfile_dump_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int DATA_W   = 32,
   parameter int CYC_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CYC_W-1:0]  num_cycles,
   output logic              cpu_en,
   input  logic [IDX_W-1:0]  proc_rs1,
   output logic [IDX_W-1:0]  rf_rs1,
   input  logic [DATA_W-1:0] rf_dataA,
   output logic              test_mode,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [IDX_W-1:0]  dump_reg,
   output logic [DATA_W-1:0] dump_data,
   output logic [CYC_W-1:0]  cycle_count,
   output logic              busy,
   output logic              done
);

   if (IDX_W != $clog2(NUM_REGS)) begin : g_idx_w_check
      $error("IDX_W must equal log2(NUM_REGS)");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_SELECT,
      S_PRESENT,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   state_t             state, state_nxt;
   logic [CYC_W-1:0]   budget, budget_nxt;
   logic [CYC_W-1:0]   cycle_count_nxt;
   logic [IDX_W-1:0]   scan_idx, scan_idx_nxt;
   logic [IDX_W-1:0]   dump_reg_nxt;
   logic [DATA_W-1:0]  dump_data_nxt;

   // Only path that is not registered: the read-port ownership mux.
   assign rf_rs1 = test_mode ? scan_idx : proc_rs1;

   // NOTE: every variable gets a hold default before the case so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt       = state;
      budget_nxt      = budget;
      cycle_count_nxt = cycle_count;
      scan_idx_nxt    = scan_idx;
      dump_reg_nxt    = dump_reg;
      dump_data_nxt   = dump_data;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               budget_nxt      = num_cycles;
               cycle_count_nxt = '0;
               scan_idx_nxt    = '0;
               state_nxt       = (num_cycles != '0) ? S_RUN : S_SELECT;
            end
         end
         S_RUN: begin
            cycle_count_nxt = cycle_count + CYC_W'(1);
            if (cycle_count == budget - CYC_W'(1)) begin
               state_nxt = S_SELECT;
            end
         end
         S_SELECT: begin
            // rf_rs1 has carried scan_idx for a full cycle, so rf_dataA is settled.
            dump_data_nxt = rf_dataA;
            dump_reg_nxt  = scan_idx;
            state_nxt     = S_PRESENT;
         end
         S_PRESENT: begin
            if (dump_ready) begin
               if (scan_idx == LAST_IDX) begin
                  state_nxt = S_DONE;
               end else begin
                  scan_idx_nxt = scan_idx + IDX_W'(1);
                  state_nxt    = S_SELECT;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         budget      <= '0;
         cycle_count <= '0;
         scan_idx    <= '0;
         dump_reg    <= '0;
         dump_data   <= '0;
         cpu_en      <= 1'b0;
         test_mode   <= 1'b0;
         dump_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         budget      <= budget_nxt;
         cycle_count <= cycle_count_nxt;
         scan_idx    <= scan_idx_nxt;
         dump_reg    <= dump_reg_nxt;
         dump_data   <= dump_data_nxt;
         // Flags are decoded from the next state so they change on the same edge as it.
         cpu_en      <= (state_nxt == S_RUN);
         test_mode   <= (state_nxt inside {S_SELECT, S_PRESENT, S_DONE});
         dump_valid  <= (state_nxt == S_PRESENT);
         busy        <= (state_nxt inside {S_RUN, S_SELECT, S_PRESENT});
         done        <= (state_nxt == S_DONE);
      end
   end

endmodule
